// File: rtl/router_buffer.sv
// Load-enabled holding register for one router word. Stages a packet or
// token word between router-core pipeline steps; async reset clears it.
module router_buffer #(
  parameter int WIDTH = 55
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] new_value,
  input  logic             buffer_select,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] stored;

  // Reset wins over any load, so unknown select/data during reset never leaks in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                stored <= '0;
    else if (buffer_select) stored <= new_value;
  end

  assign out = stored;

endmodule

// File: tb/tb_router_buffer.sv
// Directed bench for router_buffer: vector table plus hand-written
// sequences for async reset, mid-cycle changes and back-to-back loads.
module tb_router_buffer;
  localparam int WIDTH = 55;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] new_value;
  logic             buffer_select;
  logic [WIDTH-1:0] out;

  int tests = 0;
  int fails = 0;

  router_buffer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .new_value(new_value),
    .buffer_select(buffer_select), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             sel;
    logic [WIDTH-1:0] nv;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [WIDTH-1:0] got,
                     input logic [WIDTH-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: out=%h expected=%h", name, got, exp);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 55'd100, 55'd100};
    vecs[1] = '{1'b0, 1'b0, 55'd50,  55'd100};
    vecs[2] = '{1'b0, 1'b0, 55'd42,  55'd100};
    vecs[3] = '{1'b0, 1'b1, 55'd42,  55'd42};
    vecs[4] = '{1'b0, 1'b1, 55'h7F_FFFF_FFFF_FFFF, 55'h7F_FFFF_FFFF_FFFF};
    vecs[5] = '{1'b0, 1'b1, 55'h40_0000_0000_0001, 55'h40_0000_0000_0001};
    vecs[6] = '{1'b0, 1'b0, 55'd0,   55'h40_0000_0000_0001};
    vecs[7] = '{1'b1, 1'b1, 55'd123, 55'd0};
    vecs[8] = '{1'b0, 1'b0, 55'd5,   55'd0};
    vecs[9] = '{1'b0, 1'b1, 55'd5,   55'd5};

    // Reset with unknown select/data, checked before any clock edge.
    rst = 1'b1; buffer_select = 1'bx; new_value = 'x;
    #2;
    chk("reset_async_initial", out, '0);
    @(posedge clk); #1;
    chk("reset_held_edge", out, '0);
    @(negedge clk);
    rst = 1'b0; buffer_select = 1'b0; new_value = 55'd77;
    @(posedge clk); #1;
    chk("post_release_no_load", out, '0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; buffer_select = vecs[i].sel; new_value = vecs[i].nv;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), out, vecs[i].exp);
    end

    // Mid-cycle changes with select low must not disturb out.
    @(negedge clk);
    buffer_select = 1'b0; new_value = 55'd9;
    #2 new_value = 55'd11;
    #1 chk("midcycle_hold", out, 55'd5);
    @(posedge clk); #1;
    chk("hold_across_edge", out, 55'd5);

    // Async reset mid-operation, then release with select already high.
    @(negedge clk);
    buffer_select = 1'b1; new_value = 55'd42;
    @(posedge clk); #1;
    chk("load_before_reset", out, 55'd42);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("reset_async_midcycle", out, '0);
    @(posedge clk); #1;
    chk("reset_ignores_select", out, '0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("release_no_capture", out, '0);
    @(posedge clk); #1;
    chk("load_after_release", out, 55'd42);

    // Back-to-back loads: out tracks new_value one cycle late.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      buffer_select = 1'b1; new_value = WIDTH'(i);
      if (i > 0) chk($sformatf("stream_pre%0d", i), out, WIDTH'(i - 1));
      @(posedge clk); #1;
      chk($sformatf("stream%0d", i), out, WIDTH'(i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, out=%h", out);
    $fatal(1, "timeout");
  end

endmodule
